// File: rtl/env_readout_pkg.sv
// env_readout_pkg
// Purpose: shared grid geometry and readout state encoding for env_readout.
// Contents: coordinate/signal widths, default grid extents, sugar-count width,
//           readout FSM state enum.
package env_readout_pkg;

  localparam int X_bits      = 8;
  localparam int Y_bits      = 7;
  localparam int SIGNAL_bits = 4;
  localparam int X_max       = 159;
  localparam int Y_max       = 119;
  localparam int COUNT_bits  = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_TRAILER = 2'd3
  } readout_state_e;

endpackage

// File: rtl/env_readout_fifo.sv
// env_readout_fifo
// Purpose: 2-deep first-word-fall-through buffer for captured cell words.
// Ports:
//   clk      in   clock
//   i_rst    in   synchronous active-high reset (empties the buffer)
//   i_push   in   write i_data (caller never pushes into a full buffer without a pop)
//   i_data   in   W-bit word
//   i_pop    in   discard the head word
//   o_data   out  head word (valid when o_count != 0)
//   o_count  out  occupancy 0..2
module env_readout_fifo
  import env_readout_pkg::*;
#(
  parameter int W = SIGNAL_bits + 2
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/env_readout.sv
// env_readout
// Purpose: walks the environment lookup port in raster order and streams one
//          {sugar, signal} word per cell over valid/ready; holds the simulation
//          while a dump is in progress.
// Optional feature macro: ENV_READOUT_SUGARCOUNT_EN -- counts sugar cells and
//          appends a trailer word carrying the count; exposes sugar_count.
// Ports:
//   clk, RESET_SIM (sync, active-high), start (1-cycle dump request)
//   lookup_X/lookup_Y out : environment lookup address (held between issues)
//   lookup_sugar/lookup_signal in : lookup data, one cycle after the address
//   out_valid/out_ready/out_data/out_last : output stream
//   hold_sim, busy out : high for the whole dump
//   sugar_count out (macro only) : running sugar-cell count
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_SCAN    | issuing lookup addresses as buffer credit allows
// ST_DRAIN   | all addresses issued, emptying pipeline and buffer
// ST_TRAILER | presenting the sugar-count word (macro only)
module env_readout #(
  parameter int X_bits      = env_readout_pkg::X_bits,
  parameter int Y_bits      = env_readout_pkg::Y_bits,
  parameter int SIGNAL_bits = env_readout_pkg::SIGNAL_bits,
  parameter int X_max       = env_readout_pkg::X_max,
  parameter int Y_max       = env_readout_pkg::Y_max
`ifdef ENV_READOUT_SUGARCOUNT_EN
  , parameter int COUNT_bits = env_readout_pkg::COUNT_bits
`endif
) (
  input  logic                   clk,
  input  logic                   RESET_SIM,
  input  logic                   start,
  output logic [X_bits-1:0]      lookup_X,
  output logic [Y_bits-1:0]      lookup_Y,
  input  logic                   lookup_sugar,
  input  logic [SIGNAL_bits-1:0] lookup_signal,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIGNAL_bits:0]   out_data,
  output logic                   out_last,
  output logic                   hold_sim,
  output logic                   busy
`ifdef ENV_READOUT_SUGARCOUNT_EN
  , output logic [COUNT_bits-1:0] sugar_count
`endif
);
  import env_readout_pkg::*;

  localparam int W = SIGNAL_bits + 2;
  localparam bit ONE_CELL = (X_max == 0) && (Y_max == 0);
`ifdef ENV_READOUT_SUGARCOUNT_EN
  localparam bit TAG_LAST = 1'b0;  // the trailer carries out_last instead
`else
  localparam bit TAG_LAST = 1'b1;
`endif

  readout_state_e    r_state;
  logic [X_bits-1:0] r_x;
  logic [Y_bits-1:0] r_y;
  // r_addr_live: address on the bus was issued this cycle (data next cycle).
  // r_data_live: lookup data on the inputs this cycle belongs to an issue.
  logic              r_addr_live, r_addr_last;
  logic              r_data_live, r_data_last;

  logic [X_bits-1:0] w_nx;
  logic [Y_bits-1:0] w_ny;
  logic              w_at_end_x, w_next_last;
  logic [1:0]        w_fifo_count, w_occ_next;
  logic [W-1:0]      w_fifo_head, w_capture, w_word;
  logic              w_fifo_empty, w_push, w_pop, w_xfer, w_issue, w_drained;

  assign w_at_end_x  = (r_x == X_bits'(X_max));
  assign w_nx        = w_at_end_x ? '0 : r_x + 1'b1;
  assign w_ny        = w_at_end_x ? r_y + 1'b1 : r_y;
  assign w_next_last = (w_nx == X_bits'(X_max)) && (w_ny == Y_bits'(Y_max));

  assign w_fifo_empty = (w_fifo_count == 2'd0);
  assign w_capture    = {r_data_last, lookup_sugar, lookup_signal};
  // Fall-through: with an empty buffer the word arriving this cycle is
  // presented directly, so only stalled words occupy the buffer.
  assign w_word = w_fifo_empty ? w_capture : w_fifo_head;
  assign w_xfer = out_valid && out_ready;
  assign w_pop  = !w_fifo_empty && out_ready;
  assign w_push = r_data_live && !(w_fifo_empty && out_ready);
  assign w_occ_next = w_fifo_count + {1'b0, w_push} - {1'b0, w_pop};
  // A new address now returns data two cycles later; the buffer plus the read
  // already in flight must leave room for it.
  assign w_issue   = (r_state == ST_SCAN) &&
                     ((3'(w_occ_next) + 3'(r_addr_live)) < 3'd2);
  assign w_drained = (w_occ_next == 2'd0) && !r_addr_live;

  env_readout_fifo #(.W(W)) u_fifo (
    .clk     (clk),
    .i_rst   (RESET_SIM),
    .i_push  (w_push),
    .i_data  (w_capture),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (RESET_SIM) begin
      r_state     <= ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_addr_live <= 1'b0;
      r_addr_last <= 1'b0;
      r_data_live <= 1'b0;
      r_data_last <= 1'b0;
    end else begin
      r_data_live <= r_addr_live;
      r_data_last <= r_addr_last;
      r_addr_live <= 1'b0;
      r_addr_last <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_x         <= '0;
          r_y         <= '0;
          r_addr_live <= 1'b1;
          r_addr_last <= TAG_LAST && ONE_CELL;
          r_state     <= ONE_CELL ? ST_DRAIN : ST_SCAN;
        end
        ST_SCAN: if (w_issue) begin
          r_x         <= w_nx;
          r_y         <= w_ny;
          r_addr_live <= 1'b1;
          r_addr_last <= TAG_LAST && w_next_last;
          if (w_next_last) r_state <= ST_DRAIN;
        end
`ifdef ENV_READOUT_SUGARCOUNT_EN
        ST_DRAIN:   if (w_drained) r_state <= ST_TRAILER;
        ST_TRAILER: if (out_ready) r_state <= ST_IDLE;
`else
        ST_DRAIN:   if (w_drained) r_state <= ST_IDLE;
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ENV_READOUT_SUGARCOUNT_EN
  logic [COUNT_bits-1:0] r_count;

  always_ff @(posedge clk) begin
    if (RESET_SIM)                        r_count <= '0;
    else if (r_state == ST_IDLE && start) r_count <= '0;
    else if (r_data_live && lookup_sugar) r_count <= r_count + 1'b1;
  end

  assign sugar_count = r_count;
`endif

  always_comb begin
    out_valid = !w_fifo_empty || r_data_live;
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = w_word[SIGNAL_bits:0];
      out_last = w_word[W-1];
    end
`ifdef ENV_READOUT_SUGARCOUNT_EN
    if (r_state == ST_TRAILER) begin
      out_valid = 1'b1;
      out_data  = r_count[SIGNAL_bits:0];
      out_last  = 1'b1;
    end
`endif
  end

  assign lookup_X = r_x;
  assign lookup_Y = r_y;
  assign busy     = (r_state != ST_IDLE);
  assign hold_sim = busy;

endmodule

// File: tb/tb_env_readout.sv
module tb_env_readout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small 4x2 grid DUT
  logic       rst_s, start_s, ready_s, sug_s, valid_s, last_s, hold_s, busy_s;
  logic [7:0] lx_s;
  logic [6:0] ly_s;
  logic [3:0] sig_s;
  logic [4:0] data_s;
  // full 160x120 grid DUT
  logic       rst_f, start_f, ready_f, sug_f, valid_f, last_f, hold_f, busy_f;
  logic [7:0] lx_f;
  logic [6:0] ly_f;
  logic [3:0] sig_f;
  logic [4:0] data_f;
`ifdef ENV_READOUT_SUGARCOUNT_EN
  logic [14:0] sc_s, sc_f;
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  env_readout #(.X_max(3), .Y_max(1)) dut_s (
    .clk(clk), .RESET_SIM(rst_s), .start(start_s),
    .lookup_X(lx_s), .lookup_Y(ly_s), .lookup_sugar(sug_s), .lookup_signal(sig_s),
    .out_valid(valid_s), .out_ready(ready_s), .out_data(data_s), .out_last(last_s),
    .hold_sim(hold_s), .busy(busy_s)
`ifdef ENV_READOUT_SUGARCOUNT_EN
    , .sugar_count(sc_s)
`endif
  );

  env_readout dut_f (
    .clk(clk), .RESET_SIM(rst_f), .start(start_f),
    .lookup_X(lx_f), .lookup_Y(ly_f), .lookup_sugar(sug_f), .lookup_signal(sig_f),
    .out_valid(valid_f), .out_ready(ready_f), .out_data(data_f), .out_last(last_f),
    .hold_sim(hold_f), .busy(busy_f)
`ifdef ENV_READOUT_SUGARCOUNT_EN
    , .sugar_count(sc_f)
`endif
  );

  // environment model: registered lookup, sugar=(X==Y), signal=X+4*Y
  always @(posedge clk) begin
    sug_s <= ({1'b0, ly_s} == lx_s);
    sig_s <= lx_s[3:0] + {ly_s[1:0], 2'b00};
    sug_f <= ({1'b0, ly_f} == lx_f);
    sig_f <= lx_f[3:0] + {ly_f[1:0], 2'b00};
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [4:0] exp_w [$];
  logic [4:0] got_w [$];
  logic       got_l [$];
  int busy_cycles, last_xfer_cyc, first_valid_cyc, unstable, max_ahead;
  bit timed_out;

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    case (c % 4)
      0: return 1'b1;
      1: return 1'b0;
      2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Drives one dump on the small DUT and records what comes out.
  task automatic run_small(input int mode, input int restart_cyc);
    logic pv, pr, pl;
    logic [4:0] pd;
    int acc, idx;
    bit done;
    got_w.delete(); got_l.delete();
    busy_cycles = 0; last_xfer_cyc = -1; first_valid_cyc = -1;
    unstable = 0; max_ahead = 0; timed_out = 1'b0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; acc = 0; done = 1'b0;
    @(negedge clk);
    start_s = 1'b1;
    ready_s = rdy(mode, 0);
    for (int cyc = 1; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      start_s = (cyc == restart_cyc);
      ready_s = rdy(mode, cyc);
      #1;
      if (busy_s) busy_cycles++;
      if (valid_s && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pv && !pr && (!valid_s || data_s !== pd || last_s !== pl)) unstable++;
      if (busy_s) begin
        idx = int'(ly_s) * 4 + int'(lx_s);
        if (idx + 1 - acc > max_ahead) max_ahead = idx + 1 - acc;
      end
      if (valid_s && ready_s) begin
        got_w.push_back(data_s);
        got_l.push_back(last_s);
        acc++;
        last_xfer_cyc = cyc;
      end
      pv = valid_s; pr = ready_s; pd = data_s; pl = last_s;
      if (!busy_s) done = 1'b1;
    end
    if (!done) timed_out = 1'b1;
    start_s = 1'b0;
    ready_s = 1'b1;
  endtask

  task automatic test_reset;
    rst_s = 1'b1; rst_f = 1'b1; start_s = 1'b0; start_f = 1'b0;
    ready_s = 1'b1; ready_f = 1'b1;
    repeat (3) @(negedge clk);
    rst_s = 1'b0; rst_f = 1'b0;
    #1;
    n_checks++; if (lx_s !== 8'd0 || ly_s !== 7'd0) $display("FAIL reset_addr: got (%0d,%0d) expected (0,0)", lx_s, ly_s); else n_pass++;
    n_checks++; if (valid_s !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_s); else n_pass++;
    n_checks++; if (data_s !== 5'd0) $display("FAIL reset_data: got %h expected 00", data_s); else n_pass++;
    n_checks++; if (last_s !== 1'b0) $display("FAIL reset_last: got %b expected 0", last_s); else n_pass++;
    n_checks++; if (busy_s !== 1'b0 || hold_s !== 1'b0) $display("FAIL reset_busy_hold: got %b/%b expected 0/0", busy_s, hold_s); else n_pass++;
`ifdef ENV_READOUT_SUGARCOUNT_EN
    n_checks++; if (sc_s !== 15'd0) $display("FAIL reset_sugar_count: got %0d expected 0", sc_s); else n_pass++;
`endif
  endtask

  task automatic check_frame(input string tag);
    n_checks++;
    if (timed_out) $display("FAIL %s_timeout: got no end of dump expected busy to fall", tag); else n_pass++;
    n_checks++;
    if (got_w.size() !== exp_w.size()) $display("FAIL %s_count: got %0d words expected %0d", tag, got_w.size(), exp_w.size());
    else n_pass++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      n_checks++;
      if (got_w[i] !== exp_w[i]) $display("FAIL %s_word%0d: got %h expected %h", tag, i, got_w[i], exp_w[i]);
      else n_pass++;
      n_checks++;
      if (got_l[i] !== (i == exp_w.size() - 1)) $display("FAIL %s_last%0d: got %b expected %b", tag, i, got_l[i], (i == exp_w.size() - 1));
      else n_pass++;
    end
  endtask

  task automatic test_stream;
    run_small(0, -1);
    check_frame("stream");
    n_checks++; if (first_valid_cyc !== 2) $display("FAIL stream_first_valid: got cycle %0d expected 2", first_valid_cyc); else n_pass++;
    n_checks++; if (last_xfer_cyc !== 9 + EXTRA) $display("FAIL stream_last_xfer: got cycle %0d expected %0d", last_xfer_cyc, 9 + EXTRA); else n_pass++;
    n_checks++; if (busy_cycles !== 9 + EXTRA) $display("FAIL stream_busy_cycles: got %0d expected %0d", busy_cycles, 9 + EXTRA); else n_pass++;
    n_checks++; if (max_ahead !== 2) $display("FAIL stream_ahead: got %0d expected 2", max_ahead); else n_pass++;
`ifdef ENV_READOUT_SUGARCOUNT_EN
    n_checks++; if (sc_s !== 15'd2) $display("FAIL stream_sugar_count: got %0d expected 2", sc_s); else n_pass++;
`endif
  endtask

  task automatic test_backpressure;
    run_small(1, -1);
    check_frame("bp");
    n_checks++; if (unstable !== 0) $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", unstable); else n_pass++;
    n_checks++; if (max_ahead > 2) $display("FAIL bp_ahead: got %0d expected at most 2", max_ahead); else n_pass++;
  endtask

  task automatic test_start_ignored;
    run_small(0, 4);
    check_frame("restart");
    n_checks++; if (busy_cycles !== 9 + EXTRA) $display("FAIL restart_busy_cycles: got %0d expected %0d", busy_cycles, 9 + EXTRA); else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start_s = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      rst_s = (cyc == 5);
    end
    #1;
    n_checks++; if (valid_s !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid_s); else n_pass++;
    n_checks++; if (busy_s !== 1'b0 || hold_s !== 1'b0) $display("FAIL rstmid_busy_hold: got %b/%b expected 0/0", busy_s, hold_s); else n_pass++;
    n_checks++; if (lx_s !== 8'd0 || ly_s !== 7'd0) $display("FAIL rstmid_addr: got (%0d,%0d) expected (0,0)", lx_s, ly_s); else n_pass++;
    run_small(0, -1);
    check_frame("rstmid_fresh");
  endtask

  task automatic test_full_grid;
    int nw, nlast, last_cyc;
    bit done;
    nw = 0; nlast = 0; last_cyc = -1; done = 1'b0;
    @(negedge clk);
    start_f = 1'b1;
    for (int cyc = 1; cyc < 20100 && !done; cyc++) begin
      @(negedge clk);
      start_f = 1'b0;
      #1;
      if (valid_f && ready_f) begin
        nw++;
        last_cyc = cyc;
        if (last_f) nlast++;
      end
      if (!busy_f) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL full_timeout: got no end of dump expected busy to fall"); else n_pass++;
    n_checks++; if (nw !== 19200 + EXTRA) $display("FAIL full_count: got %0d words expected %0d", nw, 19200 + EXTRA); else n_pass++;
    n_checks++; if (last_cyc !== 19201 + EXTRA) $display("FAIL full_last_cycle: got %0d expected %0d", last_cyc, 19201 + EXTRA); else n_pass++;
    n_checks++; if (nlast !== 1) $display("FAIL full_last_marks: got %0d expected 1", nlast); else n_pass++;
    n_checks++; if (lx_f !== 8'd159 || ly_f !== 7'd119) $display("FAIL full_final_addr: got (%0d,%0d) expected (159,119)", lx_f, ly_f); else n_pass++;
  endtask

  initial begin
    exp_w = '{5'h10, 5'h01, 5'h02, 5'h03, 5'h04, 5'h15, 5'h06, 5'h07};
`ifdef ENV_READOUT_SUGARCOUNT_EN
    exp_w.push_back(5'h02);
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_full_grid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
